i2c_dac_sequencer: RTL and testbench

- Wishbone master that sits directly upstream of i2c_master_top and drives its register interface.
- Converts a DAC write request (8-bit register pointer plus 16-bit sample) into one I2C write transaction: START, addr+W, pointer, data_hi, data_lo, STOP.
- Programs the core prescaler and enable bit once after reset.
- Reports completion, NACK, arbitration loss and timeout to the laser projector control logic.

---
 rtl/i2c_dac_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_i2c_dac_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_dac_sequencer.sv
// i2c_dac_sequencer: Wishbone master in front of i2c_master_top. It programs
// the prescaler and core enable once after reset, then turns each DAC request
// (pointer byte + 16-bit sample) into one I2C write transaction:
// START, addr+W, pointer, data_hi, data_lo, STOP.
module i2c_dac_sequencer #(
    parameter logic [15:0] PRESCALE   = 16'h0063,
    parameter logic [6:0]  SLAVE_ADDR = 7'h60,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic        wb_clk_i,
    input  logic        arst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_ptr,
    input  logic [15:0] req_data,
    output logic        done,
    output logic        err_nack,
    output logic        err_al,
    output logic        err_timeout,
    output logic        init_done,
    output logic [2:0]  wbm_adr_o,
    output logic [7:0]  wbm_dat_o,
    input  logic [7:0]  wbm_dat_i,
    output logic        wbm_we_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i
);

    localparam logic [2:0] REG_PRERLO = 3'd0;
    localparam logic [2:0] REG_PRERHI = 3'd1;
    localparam logic [2:0] REG_CTR    = 3'd2;
    localparam logic [2:0] REG_TXR    = 3'd3;
    localparam logic [2:0] REG_CRSR   = 3'd4;   // CR on write, SR on read

    localparam int SR_RXACK = 7;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;

    typedef enum logic [3:0] {
        INIT_PRELO, INIT_PREHI, INIT_CTR, IDLE, LOAD_TXR, ISSUE_CR,
        POLL_SR, CHECK, STOP_CR, STOP_POLL, FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] tmo_q, tmo_d;
    logic        sr_al_q, sr_al_d;
    logic        sr_rxack_q, sr_rxack_d;
    logic        init_done_q, init_done_d;
    logic        err_nack_q, err_nack_d;
    logic        err_al_q, err_al_d;
    logic        err_tmo_q, err_tmo_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [2:0]  adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;

    // Access the current state would like to launch on the bus.
    logic        acc_req;
    logic        acc_we;
    logic [2:0]  acc_adr;
    logic [7:0]  acc_dat;
    logic        acc_done;
    logic [7:0]  tx_byte;
    logic [7:0]  cr_wr;

    // SR bits the sequencer does not act on.
    logic unused_sr;
    assign unused_sr = ^{wbm_dat_i[6], wbm_dat_i[4:2], wbm_dat_i[0]};

    assign acc_done = cyc_q & wbm_ack_i;

    // Byte and CR command for the current position within the transaction.
    always_comb begin
        unique case (byte_cnt_q)
            2'd0:    begin tx_byte = {SLAVE_ADDR, 1'b0}; cr_wr = 8'h90; end
            2'd1:    begin tx_byte = ptr_q;              cr_wr = 8'h10; end
            2'd2:    begin tx_byte = data_q[15:8];       cr_wr = 8'h10; end
            default: begin tx_byte = data_q[7:0];        cr_wr = 8'h50; end
        endcase
    end

    // Sequencer next-state logic and Wishbone access launch/retire.
    always_comb begin
        // NOTE: every variable gets its default first so no path through the
        // case leaves one unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        ptr_d       = ptr_q;
        data_d      = data_q;
        tmo_d       = tmo_q;
        sr_al_d     = sr_al_q;
        sr_rxack_d  = sr_rxack_q;
        init_done_d = init_done_q;
        err_nack_d  = err_nack_q;
        err_al_d    = err_al_q;
        err_tmo_d   = err_tmo_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        acc_req     = 1'b0;
        acc_we      = 1'b1;
        acc_adr     = REG_CRSR;
        acc_dat     = 8'h00;

        // Retire the outstanding access: drop cyc/stb, capture read data.
        if (acc_done) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
            if (!we_q) begin
                sr_al_d    = wbm_dat_i[SR_AL];
                sr_rxack_d = wbm_dat_i[SR_RXACK];
            end
        end

        unique case (state_q)
            INIT_PRELO: begin
                acc_req = 1'b1; acc_adr = REG_PRERLO; acc_dat = PRESCALE[7:0];
                if (acc_done) state_d = INIT_PREHI;
            end
            INIT_PREHI: begin
                acc_req = 1'b1; acc_adr = REG_PRERHI; acc_dat = PRESCALE[15:8];
                if (acc_done) state_d = INIT_CTR;
            end
            INIT_CTR: begin
                acc_req = 1'b1; acc_adr = REG_CTR; acc_dat = 8'h80;
                if (acc_done) begin
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                if (req_valid && init_done_q) begin
                    ptr_d      = req_ptr;
                    data_d     = req_data;
                    byte_cnt_d = 2'd0;
                    err_nack_d = 1'b0;
                    err_al_d   = 1'b0;
                    err_tmo_d  = 1'b0;
                    state_d    = LOAD_TXR;
                end
            end
            LOAD_TXR: begin
                acc_req = 1'b1; acc_adr = REG_TXR; acc_dat = tx_byte;
                if (acc_done) state_d = ISSUE_CR;
            end
            ISSUE_CR: begin
                acc_req = 1'b1; acc_adr = REG_CRSR; acc_dat = cr_wr;
                if (acc_done) begin
                    tmo_d   = 16'd0;
                    state_d = POLL_SR;
                end
            end
            POLL_SR, STOP_POLL: begin
                if (tmo_q != '1) tmo_d = tmo_q + 16'd1;
                if (acc_done) begin
                    if (!wbm_dat_i[SR_TIP]) state_d = (state_q == POLL_SR) ? CHECK : FINISH;
                end else if (!cyc_q) begin
                    // The timeout is only acted on between reads so that an
                    // access in flight is never abandoned.
                    if (tmo_q >= TIMEOUT) begin
                        err_tmo_d = 1'b1;
                        state_d   = (state_q == POLL_SR) ? STOP_CR : FINISH;
                    end else begin
                        acc_req = 1'b1; acc_we = 1'b0; acc_adr = REG_CRSR;
                    end
                end
            end
            CHECK: begin
                if (sr_al_q) begin
                    err_al_d = 1'b1;
                    state_d  = FINISH;
                end else if (sr_rxack_q) begin
                    err_nack_d = 1'b1;
                    state_d    = STOP_CR;
                end else if (byte_cnt_q == 2'd3) begin
                    state_d = FINISH;
                end else begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    state_d    = LOAD_TXR;
                end
            end
            STOP_CR: begin
                acc_req = 1'b1; acc_adr = REG_CRSR; acc_dat = 8'h40;
                if (acc_done) begin
                    tmo_d   = 16'd0;
                    state_d = STOP_POLL;
                end
            end
            FINISH: begin
                err_nack_d = 1'b0;
                err_al_d   = 1'b0;
                err_tmo_d  = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = INIT_PRELO;
        endcase

        // A new access starts only from an idle bus cycle, which guarantees
        // the gap between consecutive accesses.
        if (acc_req && !cyc_q) begin
            cyc_d = 1'b1;
            we_d  = acc_we;
            adr_d = acc_adr;
            dat_d = acc_dat;
        end
    end

    // State and bus registers; reset abandons any access immediately.
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q     <= INIT_PRELO;
            byte_cnt_q  <= 2'd0;
            ptr_q       <= 8'h00;
            data_q      <= 16'h0000;
            tmo_q       <= 16'd0;
            sr_al_q     <= 1'b0;
            sr_rxack_q  <= 1'b0;
            init_done_q <= 1'b0;
            err_nack_q  <= 1'b0;
            err_al_q    <= 1'b0;
            err_tmo_q   <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 3'd0;
            dat_q       <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            ptr_q       <= ptr_d;
            data_q      <= data_d;
            tmo_q       <= tmo_d;
            sr_al_q     <= sr_al_d;
            sr_rxack_q  <= sr_rxack_d;
            init_done_q <= init_done_d;
            err_nack_q  <= err_nack_d;
            err_al_q    <= err_al_d;
            err_tmo_q   <= err_tmo_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
        end
    end

    assign req_ready   = (state_q == IDLE) && init_done_q;
    assign done        = (state_q == FINISH);
    assign err_nack    = err_nack_q;
    assign err_al      = err_al_q;
    assign err_timeout = err_tmo_q;
    assign init_done   = init_done_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_we_o    = we_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_cyc_o   = cyc_q;

endmodule

// File: tb/tb_i2c_dac_sequencer.sv
// Bench for i2c_dac_sequencer: a Wishbone slave model standing in for
// i2c_master_top, a scoreboard of expected register writes, a vector table of
// DAC requests with expected status flags, and hand-written reset sequences.
module tb_i2c_dac_sequencer;

    typedef struct packed {
        logic [2:0] adr;
        logic [7:0] dat;
    } wr_t;

    typedef struct {
        logic [7:0]  ptr;
        logic [15:0] data;
        int          polls;      // SR reads returning TIP=1 before it clears
        int          fault_byte; // byte whose final SR carries fault_sr (-1: none)
        logic [7:0]  fault_sr;
        bit          hang;       // TIP never clears
        bit          exp_nack;
        bit          exp_al;
        bit          exp_to;
    } vec_t;

    logic        clk = 1'b0;
    logic        arst_i = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_ptr = 8'h00;
    logic [15:0] req_data = 16'h0000;
    logic        done, err_nack, err_al, err_timeout, init_done;
    logic [2:0]  wbm_adr_o;
    logic [7:0]  wbm_dat_o;
    logic [7:0]  wbm_dat_i = 8'h00;
    logic        wbm_we_o, wbm_stb_o, wbm_cyc_o;
    logic        wbm_ack_i = 1'b0;

    int  n_vec  = 0;
    int  n_miss = 0;
    int  done_cnt = 0;
    wr_t exp_q[$];

    // Slave model configuration and progress
    int         cfg_polls = 0;
    int         cfg_fault_byte = -1;
    logic [7:0] cfg_fault_sr = 8'h00;
    bit         cfg_hang = 1'b0;
    int         cur_byte = -1;
    int         polls_left = 0;
    int         sr_reads = 0;
    bit         in_stop = 1'b0;

    vec_t vecs[7];

    i2c_dac_sequencer #(
        .PRESCALE   (16'h0063),
        .SLAVE_ADDR (7'h60),
        .TIMEOUT    (16'd20)
    ) dut (
        .wb_clk_i    (clk),
        .arst_i      (arst_i),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_ptr     (req_ptr),
        .req_data    (req_data),
        .done        (done),
        .err_nack    (err_nack),
        .err_al      (err_al),
        .err_timeout (err_timeout),
        .init_done   (init_done),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_we_o    (wbm_we_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_ack_i   (wbm_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Slave model: acks each strobe in its first cycle, scores writes
    // against the expected queue and serves SR reads.
    always @(negedge clk) begin
        if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
            wbm_ack_i = 1'b1;
            if (wbm_we_o) begin
                wbm_dat_i = 8'h00;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL wb_write: got adr %0d dat %02h, expected no write", wbm_adr_o, wbm_dat_o);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wb_write", {21'd0, wbm_adr_o, wbm_dat_o}, {21'd0, e.adr, e.dat});
                end
                if (wbm_adr_o == 3'd4) begin
                    if (wbm_dat_o == 8'h40) in_stop = 1'b1;
                    else cur_byte++;
                    polls_left = cfg_polls;
                    sr_reads   = 0;
                end
            end else begin
                check("sr_read_adr", {29'd0, wbm_adr_o}, 32'd4);
                sr_reads++;
                if (cfg_hang) wbm_dat_i = 8'h02;
                else if (polls_left > 0) begin
                    polls_left--;
                    wbm_dat_i = 8'h02;
                end else if (!in_stop && cur_byte == cfg_fault_byte) wbm_dat_i = cfg_fault_sr;
                else wbm_dat_i = 8'h00;
            end
        end else begin
            wbm_ack_i = 1'b0;
        end
    end

    // Count done pulses at the clock edge that ends them.
    always @(posedge clk) if (done) done_cnt++;

    task automatic push_init();
        exp_q.push_back('{adr: 3'd0, dat: 8'h63});
        exp_q.push_back('{adr: 3'd1, dat: 8'h00});
        exp_q.push_back('{adr: 3'd2, dat: 8'h80});
    endtask

    task automatic reset_model();
        cur_byte   = -1;
        polls_left = 0;
        sr_reads   = 0;
        in_stop    = 1'b0;
    endtask

    // Expected TXR/CR pairs up to the byte where the transfer stops, then a
    // STOP write when a NACK or timeout (but not arbitration loss) occurred.
    task automatic push_txn(input vec_t v);
        logic [7:0] b [4];
        logic [7:0] cr [4];
        int last;
        bit stop;
        b[0] = 8'hC0; b[1] = v.ptr; b[2] = v.data[15:8]; b[3] = v.data[7:0];
        cr[0] = 8'h90; cr[1] = 8'h10; cr[2] = 8'h10; cr[3] = 8'h50;
        last = v.hang ? 0 : (v.fault_byte >= 0 ? v.fault_byte : 3);
        for (int i = 0; i <= last; i++) begin
            exp_q.push_back('{adr: 3'd3, dat: b[i]});
            exp_q.push_back('{adr: 3'd4, dat: cr[i]});
        end
        stop = v.hang || (v.fault_byte >= 0 && v.fault_sr[7] && !v.fault_sr[5]);
        if (stop) exp_q.push_back('{adr: 3'd4, dat: 8'h40});
    endtask

    task automatic configure(input vec_t v);
        cfg_polls      = v.polls;
        cfg_fault_byte = v.fault_byte;
        cfg_fault_sr   = v.fault_sr;
        cfg_hang       = v.hang;
        reset_model();
    endtask

    // Wait for req_ready, hand over the request; returns 0 if never ready.
    task automatic issue(input vec_t v, input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_ready"}, {31'd0, ok}, 32'd1);
        if (ok) begin
            req_valid = 1'b1;
            req_ptr   = v.ptr;
            req_data  = v.data;
            @(negedge clk);
            req_valid = 1'b0;
            check({tag, "_ready_busy"}, {31'd0, req_ready}, 32'd0);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        bit ok;
        int cnt0;
        configure(v);
        push_txn(v);
        cnt0 = done_cnt;
        issue(v, tag, ok);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done"}, {31'd0, ok}, 32'd1);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        check({tag, "_flags"}, {29'd0, err_nack, err_al, err_timeout},
              {29'd0, v.exp_nack, v.exp_al, v.exp_to});
        check({tag, "_ready_in_done"}, {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check({tag, "_clear"}, {28'd0, done, err_nack, err_al, err_timeout}, 32'd0);
        check({tag, "_done_pulses"}, done_cnt - cnt0, 32'd1);
        check({tag, "_writes_left"}, exp_q.size(), 32'd0);
    endtask

    task automatic wait_init(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (init_done) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_init_done"}, {31'd0, ok}, 32'd1);
        check({tag, "_init_writes_left"}, exp_q.size(), 32'd0);
        check({tag, "_ready_after_init"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit   ok;
        vec_t v;
        //          ptr    data      polls fb  fsr    hang nack al to
        vecs[0] = '{8'h40, 16'hABC0, 3,   -1, 8'h00, 0,   0,   0, 0};
        vecs[1] = '{8'h12, 16'h3456, 1,    0, 8'h80, 0,   1,   0, 0};
        vecs[2] = '{8'h40, 16'hABC0, 2,    2, 8'h20, 0,   0,   1, 0};
        vecs[3] = '{8'hFF, 16'h0001, 0,    3, 8'h80, 0,   1,   0, 0};
        vecs[4] = '{8'h5A, 16'h1234, 1,    1, 8'hA0, 0,   0,   1, 0};
        vecs[5] = '{8'h00, 16'hFFFF, 2,   -1, 8'h00, 0,   0,   0, 0};
        vecs[6] = '{8'h40, 16'hABC0, 0,   -1, 8'h00, 1,   0,   0, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_status", {26'd0, done, err_nack, err_al, err_timeout, init_done, req_ready}, 32'd0);
        check("reset_bus", {18'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o}, 32'd0);

        // Init sequence
        push_init();
        arst_i = 1'b1;
        wait_init("init");

        // Vector table
        foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset during POLL_SR of byte 1
        v = vecs[0];
        v.polls = 5;
        configure(v);
        push_txn(v);
        issue(v, "midrst", ok);
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (cur_byte == 1 && sr_reads >= 1 && !in_stop) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("midrst_reach_poll", {31'd0, ok}, 32'd1);
        end
        #2 arst_i = 1'b0;
        #1;
        check("midrst_bus_async", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        check("midrst_init_cleared", {30'd0, init_done, req_ready}, 32'd0);
        exp_q.delete();
        reset_model();
        push_init();
        repeat (2) @(negedge clk);
        arst_i = 1'b1;
        wait_init("rerun");

        // Back-to-back requests after recovery
        run_txn(vecs[0], "b2b_a");
        run_txn(vecs[5], "b2b_b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
